register_file: RTL and testbench

- Architectural integer register file for the single-cycle RISC-V core: 32 registers of 32 bits, x0 hardwired to zero.
- Two asynchronous (combinational) read ports feed the ALU operands.
- One synchronous write port takes the writeback result.
- Sits between instruction decode (addresses) and the ALU/writeback path.

---
 rtl/register_file.sv | 29 ++
 tb/tb_register_file.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH integer registers, x0 reads zero, two async reads, one sync write
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [ADDR_WIDTH-1:0] wa3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [N];
  logic [DATA_WIDTH-1:0] regs_d [N];
  always_comb begin
    regs_d = regs_q;
    if (we3 && wa3 != '0) regs_d[wa3] = wd3;
  end
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard-driven self-checking bench for register_file
module tb_register_file;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we3 = 1'b0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [4:0]  wa3 = '0;
  logic [31:0] wd3 = '0;
  logic [31:0] rd1, rd2;
  logic [63:0] sb [$];
  logic [63:0] e;
  int checks = 0;
  int fails = 0;

  register_file dut (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .wd3(wd3), .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ra1 = 5'd0;
    ra2 = 5'd0;
    sb.push_back(64'h0);
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL x0_pre_reset: got %h expected %h", {rd1, rd2}, e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      sb.push_back(64'h0);
      #1;
      e = sb.pop_front();
      checks++;
      if ({rd1, rd2} !== e) begin
        fails++;
        $display("FAIL reset_sweep[%0d]: got %h expected %h", i, {rd1, rd2}, e);
      end
    end
  endtask

  task automatic test_basic;
    we3 = 1'b1; wa3 = 5'd1; wd3 = 32'hAAAAAAAA;
    tick();
    we3 = 1'b0;
    ra1 = 5'd1; ra2 = 5'd0;
    sb.push_back({32'hAAAAAAAA, 32'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL basic_write: got %h expected %h", {rd1, rd2}, e);
    end
  endtask

  task automatic test_cross;
    we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h12345678;
    tick();
    we3 = 1'b0;
    ra1 = 5'd2; ra2 = 5'd1;
    sb.push_back({32'h12345678, 32'hAAAAAAAA});
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL cross_read: got %h expected %h", {rd1, rd2}, e);
    end
    ra1 = 5'd2; ra2 = 5'd2;
    sb.push_back({32'h12345678, 32'h12345678});
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL same_addr_read: got %h expected %h", {rd1, rd2}, e);
    end
  endtask

  task automatic test_x0;
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF;
    tick();
    we3 = 1'b0;
    ra1 = 5'd0; ra2 = 5'd1;
    sb.push_back({32'h0, 32'hAAAAAAAA});
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL x0_protect: got %h expected %h", {rd1, rd2}, e);
    end
  endtask

  task automatic test_same_cycle;
    we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hDEADBEEF;
    ra1 = 5'd3; ra2 = 5'd2;
    sb.push_back({32'h0, 32'h12345678});
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL no_bypass: got %h expected %h", {rd1, rd2}, e);
    end
    sb.push_back({32'hDEADBEEF, 32'h12345678});
    tick();
    we3 = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL same_cycle_after: got %h expected %h", {rd1, rd2}, e);
    end
    sb.push_back({32'hDEADBEEF, 32'h12345678});
    tick();
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL same_cycle_hold: got %h expected %h", {rd1, rd2}, e);
    end
    reset = 1'b1;
    sb.push_back({32'hDEADBEEF, 32'h12345678});
    #2;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL reset_between_edges: got %h expected %h", {rd1, rd2}, e);
    end
    reset = 1'b0;
    sb.push_back({32'hDEADBEEF, 32'h12345678});
    tick();
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL reset_glitch_ignored: got %h expected %h", {rd1, rd2}, e);
    end
  endtask

  task automatic test_reset_priority;
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd4; wd3 = 32'h55555555;
    tick();
    reset = 1'b0; we3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'd4;
      sb.push_back(64'h0);
      #1;
      e = sb.pop_front();
      checks++;
      if ({rd1, rd2} !== e) begin
        fails++;
        $display("FAIL reset_priority[%0d]: got %h expected %h", i, {rd1, rd2}, e);
      end
    end
    we3 = 1'b0; wa3 = 5'd5; wd3 = 32'h0BADF00D;
    tick();
    ra1 = 5'd5; ra2 = 5'd3;
    sb.push_back(64'h0);
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL we3_gating: got %h expected %h", {rd1, rd2}, e);
    end
    we3 = 1'b1; wa3 = 5'd31; wd3 = 32'h80000001;
    tick();
    we3 = 1'b0;
    ra1 = 5'd31; ra2 = 5'd5;
    sb.push_back({32'h80000001, 32'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({rd1, rd2} !== e) begin
      fails++;
      $display("FAIL top_reg_write: got %h expected %h", {rd1, rd2}, e);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_cross();
    test_x0();
    test_same_cycle();
    test_reset_priority();
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
